mem_ctlr: RTL and testbench

- Arbitrates the data cache and the instruction cache onto the single tagged main-memory port.
- Forwards the granted command combinationally and returns the memory's accept tag to the granted requester in the same cycle.
- Keeps a per-tag owner table so each completed transaction (data plus tag) is routed only to the cache that issued it.
- Sits between dcache/icache (upstream) and the memory model (downstream).

---
 rtl/mem_ctlr_if.sv | 41 ++++
 rtl/mem_ctlr.sv | 108 ++++++++++
 tb/tb_mem_ctlr.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctlr_if.sv
// Cache-side and memory-side bus bundle for the memory controller.
// slave is the controller view, master is the cache/memory environment view.
interface mem_ctlr_if #(
    parameter int XLEN = 32
);
    logic [1:0]      dcache2ctlr_command;
    logic [XLEN-1:0] dcache2ctlr_addr;
    logic [63:0]     dcache2ctlr_data;
    logic [1:0]      icache2ctlr_command;
    logic [XLEN-1:0] icache2ctlr_addr;
    logic [3:0]      Ctlr2proc_response;
    logic [63:0]     Ctlr2proc_data;
    logic [3:0]      Ctlr2proc_tag;
    logic [3:0]      Ctlr2icache_response;
    logic [63:0]     Ctlr2icache_data;
    logic [3:0]      Ctlr2icache_tag;
    logic [1:0]      proc2mem_command;
    logic [XLEN-1:0] proc2mem_addr;
    logic [63:0]     proc2mem_data;
    logic [3:0]      mem2proc_response;
    logic [63:0]     mem2proc_data;
    logic [3:0]      mem2proc_tag;

    modport slave (
        input  dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
        input  icache2ctlr_command, icache2ctlr_addr,
        input  mem2proc_response, mem2proc_data, mem2proc_tag,
        output Ctlr2proc_response, Ctlr2proc_data, Ctlr2proc_tag,
        output Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
        output proc2mem_command, proc2mem_addr, proc2mem_data
    );

    modport master (
        output dcache2ctlr_command, dcache2ctlr_addr, dcache2ctlr_data,
        output icache2ctlr_command, icache2ctlr_addr,
        output mem2proc_response, mem2proc_data, mem2proc_tag,
        input  Ctlr2proc_response, Ctlr2proc_data, Ctlr2proc_tag,
        input  Ctlr2icache_response, Ctlr2icache_data, Ctlr2icache_tag,
        input  proc2mem_command, proc2mem_addr, proc2mem_data
    );
endinterface

// File: rtl/mem_ctlr.sv
// Arbitrates dcache/icache onto one tagged memory port and routes
// completions back to the issuing cache through a per-tag owner table.
module mem_ctlr #(
    parameter int XLEN                = 32,
    parameter int NUM_TAGS            = 16,
    parameter int ICACHE_STARVE_LIMIT = 4
) (
    input  logic       clock,
    input  logic       reset,
    mem_ctlr_if.slave  bus,
    output logic [4:0] outstanding_cnt,
    output logic       tag_err
);
    localparam logic [1:0] BUS_NONE = 2'd0;
    localparam int SW = $clog2(ICACHE_STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(ICACHE_STARVE_LIMIT);

    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_q, owner_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [4:0]          cnt_d;

    logic            d_req, i_req, starved;
    logic            gnt_d, gnt_i, acc, hit, dup, inc;
    logic [3:0]      rsp, cpl;
    logic [XLEN-1:0] gnt_addr;

    always_comb begin
        rsp     = bus.mem2proc_response;
        cpl     = bus.mem2proc_tag;
        d_req   = bus.dcache2ctlr_command != BUS_NONE;
        i_req   = bus.icache2ctlr_command != BUS_NONE;
        starved = starve_q == LIMIT;
        gnt_i   = !reset && i_req && (!d_req || starved);
        gnt_d   = !reset && d_req && !gnt_i;
        acc     = (gnt_d || gnt_i) && rsp != 4'd0;
        hit     = !reset && cpl != 4'd0 && valid_q[cpl];
        // A completion retiring the very tag being re-accepted is not a clash
        dup     = acc && valid_q[rsp] && !(hit && cpl == rsp);
        inc     = acc && !dup;
        tag_err = !reset && ((cpl != 4'd0 && !valid_q[cpl]) || dup);
    end

    always_comb begin
        bus.proc2mem_command     = BUS_NONE;
        gnt_addr                 = '0;
        bus.proc2mem_data        = '0;
        bus.Ctlr2proc_response   = '0;
        bus.Ctlr2icache_response = '0;
        unique case (1'b1)
            gnt_d: begin
                bus.proc2mem_command   = bus.dcache2ctlr_command;
                gnt_addr               = bus.dcache2ctlr_addr;
                bus.proc2mem_data      = bus.dcache2ctlr_data;
                bus.Ctlr2proc_response = rsp;
            end
            gnt_i: begin
                bus.proc2mem_command     = bus.icache2ctlr_command;
                gnt_addr                 = bus.icache2ctlr_addr;
                bus.Ctlr2icache_response = rsp;
            end
            default: ;
        endcase
        bus.proc2mem_addr = gnt_addr;
    end

    always_comb begin
        bus.Ctlr2proc_tag    = '0;
        bus.Ctlr2proc_data   = '0;
        bus.Ctlr2icache_tag  = '0;
        bus.Ctlr2icache_data = '0;
        if (hit && owner_q[cpl]) begin
            bus.Ctlr2icache_tag  = cpl;
            bus.Ctlr2icache_data = bus.mem2proc_data;
        end else if (hit) begin
            bus.Ctlr2proc_tag  = cpl;
            bus.Ctlr2proc_data = bus.mem2proc_data;
        end
    end

    always_comb begin
        valid_d  = valid_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (hit) valid_d[cpl] = 1'b0;
        if (acc) begin
            valid_d[rsp] = 1'b1;
            owner_d[rsp] = gnt_i;
        end
        cnt_d = outstanding_cnt + 5'(inc) - 5'(hit);
        if (!i_req || (gnt_i && acc)) starve_d = '0;
        else if (!starved)            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q         <= '0;
            owner_q         <= '0;
            starve_q        <= '0;
            outstanding_cnt <= '0;
        end else begin
            valid_q         <= valid_d;
            owner_q         <= owner_d;
            starve_q        <= starve_d;
            outstanding_cnt <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_ctlr.sv
// Randomised scoreboard bench for mem_ctlr with a tag-table reference model.
// Stimulus pushes expected accepts/completions/status; a monitor pops and compares.
module tb_mem_ctlr;
    localparam int LIMIT = 4;
    localparam logic [1:0] NONE = 2'd0, LOAD = 2'd1, STORE = 2'd2;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] outstanding_cnt;
    logic       tag_err;

    mem_ctlr_if #(.XLEN(32)) bus ();

    mem_ctlr #(.XLEN(32), .NUM_TAGS(16), .ICACHE_STARVE_LIMIT(LIMIT)) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.slave),
        .outstanding_cnt(outstanding_cnt),
        .tag_err(tag_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [4:0]  cnt;
        logic        err;
        logic        acc;
        logic        cmp;
    } st_t;
    typedef struct { logic side; logic [3:0] tag; } acc_t;
    typedef struct { logic side; logic [3:0] tag; logic [63:0] data; } cmp_t;

    st_t  stq[$];
    acc_t accq[$];
    cmp_t cmpq[$];

    int checks = 0;
    int errors = 0;

    // Reference model: which tags are in flight, who owns them, icache wait streak
    bit m_valid[16];
    bit m_owner[16];
    int m_wait = 0;
    int i_grants = 0;

    function automatic int in_flight();
        int n = 0;
        for (int t = 1; t < 16; t++) n += int'(m_valid[t]);
        return n;
    endfunction

    function automatic logic [3:0] free_tag();
        int s = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
            int t = (s + k - 1) % 15 + 1;
            if (!m_valid[t]) return 4'(t);
        end
        return 4'd0;
    endfunction

    function automatic logic [3:0] owned_tag();
        int s = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
            int t = (s + k - 1) % 15 + 1;
            if (m_valid[t]) return 4'(t);
        end
        return 4'd0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic rst,
                        input logic [1:0] dc, input logic [31:0] da,
                        input logic [63:0] dd,
                        input logic [1:0] ic, input logic [31:0] ia,
                        input logic [3:0] rsp, input logic [3:0] ctg,
                        input logic [63:0] cdat);
        st_t  s;
        acc_t a;
        cmp_t c;
        bit   dreq, ireq, gi, gd, ac, ht;
        @(negedge clock);
        reset = rst;
        bus.dcache2ctlr_command = dc;
        bus.dcache2ctlr_addr    = da;
        bus.dcache2ctlr_data    = dd;
        bus.icache2ctlr_command = ic;
        bus.icache2ctlr_addr    = ia;
        bus.mem2proc_response   = rsp;
        bus.mem2proc_tag        = ctg;
        bus.mem2proc_data       = cdat;
        s = '{cmd: NONE, addr: 0, data: 0, cnt: 5'(in_flight()),
              err: 0, acc: 0, cmp: 0};
        if (rst) begin
            stq.push_back(s);
            for (int t = 0; t < 16; t++) m_valid[t] = 0;
            m_wait = 0;
            return;
        end
        dreq = dc != NONE;
        ireq = ic != NONE;
        gi = ireq && (!dreq || m_wait == LIMIT);
        gd = dreq && !gi;
        if (gd) begin
            s.cmd = dc; s.addr = da; s.data = dd;
        end else if (gi) begin
            s.cmd = ic; s.addr = ia;
        end
        ac = (gd || gi) && rsp != 0;
        ht = ctg != 0 && m_valid[ctg];
        s.err = (ctg != 0 && !ht) ||
                (ac && m_valid[rsp] && !(ht && ctg == rsp));
        s.acc = ac;
        s.cmp = ht;
        stq.push_back(s);
        if (ac) begin
            a = '{side: gi, tag: rsp};
            accq.push_back(a);
            if (gi) i_grants++;
        end
        if (ht) begin
            c = '{side: m_owner[ctg], tag: ctg, data: cdat};
            cmpq.push_back(c);
            m_valid[ctg] = 0;
        end
        if (ac) begin
            m_valid[rsp] = 1;
            m_owner[rsp] = gi;
        end
        if (!ireq || (gi && ac)) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
    endtask

    task automatic idle(input logic [3:0] ctg, input logic [63:0] cdat);
        step(0, NONE, 0, 0, NONE, 0, 0, ctg, cdat);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    initial begin
        st_t  s;
        acc_t a;
        cmp_t c;
        forever begin
            @(negedge clock);
            #3;
            if (stq.size() > 0) begin
                s = stq.pop_front();
                chk("proc2mem_command", 64'(bus.proc2mem_command), 64'(s.cmd));
                chk("proc2mem_addr", 64'(bus.proc2mem_addr), 64'(s.addr));
                chk("proc2mem_data", bus.proc2mem_data, s.data);
                chk("outstanding_cnt", 64'(outstanding_cnt), 64'(s.cnt));
                chk("tag_err", 64'(tag_err), 64'(s.err));
                if (s.acc || bus.Ctlr2proc_response != 0 ||
                    bus.Ctlr2icache_response != 0) begin
                    checks++;
                    if (accq.size() == 0) begin
                        errors++;
                        $display("FAIL accept_unexpected: dresp %0d iresp %0d expected none",
                                 bus.Ctlr2proc_response, bus.Ctlr2icache_response);
                    end else begin
                        a = accq.pop_front();
                        chk("dcache_response", 64'(bus.Ctlr2proc_response),
                            64'(a.side ? 4'd0 : a.tag));
                        chk("icache_response", 64'(bus.Ctlr2icache_response),
                            64'(a.side ? a.tag : 4'd0));
                    end
                end
                if (s.cmp || bus.Ctlr2proc_tag != 0 || bus.Ctlr2icache_tag != 0) begin
                    checks++;
                    if (cmpq.size() == 0) begin
                        errors++;
                        $display("FAIL completion_unexpected: dtag %0d itag %0d expected none",
                                 bus.Ctlr2proc_tag, bus.Ctlr2icache_tag);
                    end else begin
                        c = cmpq.pop_front();
                        chk("dcache_tag", 64'(bus.Ctlr2proc_tag),
                            64'(c.side ? 4'd0 : c.tag));
                        chk("dcache_data", bus.Ctlr2proc_data, c.side ? 64'd0 : c.data);
                        chk("icache_tag", 64'(bus.Ctlr2icache_tag),
                            64'(c.side ? c.tag : 4'd0));
                        chk("icache_data", bus.Ctlr2icache_data, c.side ? c.data : 64'd0);
                    end
                end else begin
                    chk("dcache_data_idle", bus.Ctlr2proc_data, 64'd0);
                    chk("icache_data_idle", bus.Ctlr2icache_data, 64'd0);
                end
            end
        end
    end

    initial begin
        logic [1:0]  dc, ic;
        logic [3:0]  rsp, ctg;
        int          r;
        reset = 1'b1;
        bus.dcache2ctlr_command = NONE;
        bus.dcache2ctlr_addr    = 0;
        bus.dcache2ctlr_data    = 0;
        bus.icache2ctlr_command = NONE;
        bus.icache2ctlr_addr    = 0;
        bus.mem2proc_response   = 0;
        bus.mem2proc_tag        = 0;
        bus.mem2proc_data       = 0;
        repeat (3) @(posedge clock);

        // Idle
        idle(0, 0);
        idle(0, 0);
        // dcache load, accepted as tag 3, returns five cycles later
        step(0, LOAD, 32'h1008, 0, NONE, 0, 4'd3, 0, 0);
        repeat (4) idle(0, 0);
        idle(4'd3, 64'hDEADBEEF_12345678);
        idle(0, 0);
        // Both caches every cycle, memory accepting: icache wins every 5th
        i_grants = 0;
        for (int k = 0; k < 10; k++)
            step(0, LOAD, 32'h2000 + 32'(k * 8), 0, LOAD, 32'h8000 + 32'(k * 8),
                 free_tag(), 0, 0);
        chk("icache_grants_in_10", 64'(i_grants), 64'd2);
        for (int t = 1; t < 16; t++)
            if (m_valid[t]) idle(4'(t), {$urandom, $urandom});
        // Store tag 7, icache tag 8, returned out of order
        step(0, STORE, 32'h3000, 64'h0123_4567_89AB_CDEF, NONE, 0, 4'd7, 0, 0);
        step(0, NONE, 0, 0, LOAD, 32'h4000, 4'd8, 0, 0);
        idle(4'd8, 64'h8888_0000_8888_0000);
        idle(4'd7, 64'h7777_0000_7777_0000);
        // Memory refuses dcache three times
        repeat (3) step(0, LOAD, 32'h5000, 0, NONE, 0, 0, 0, 0);
        // Completion on a never-issued tag
        idle(4'd9, 64'h9999);
        idle(0, 0);
        // Same tag retired and re-accepted in one cycle
        step(0, LOAD, 32'h6000, 0, NONE, 0, 4'd5, 0, 0);
        step(0, LOAD, 32'h6008, 0, NONE, 0, 4'd5, 4'd5, 64'h55);
        // Two tags in flight, then reset with requests still driven
        step(0, LOAD, 32'h7000, 0, LOAD, 32'h7100, 4'd2, 0, 0);
        step(1, LOAD, 32'h7008, 0, LOAD, 32'h7108, 4'd4, 4'd2, 64'h22);
        idle(0, 0);

        for (int i = 0; i < 1500; i++) begin
            if (i == 700) begin
                step(1, LOAD, 32'h100, 0, LOAD, 32'h200, 4'd1, owned_tag(), 64'h1);
                continue;
            end
            dc = 2'($urandom_range(0, 2));
            ic = $urandom_range(0, 1) != 0 ? LOAD : NONE;
            r = $urandom_range(0, 99);
            if (r < 45)      ctg = owned_tag();
            else if (r < 48) ctg = free_tag();
            else             ctg = 0;
            rsp = 0;
            r = $urandom_range(0, 99);
            if ((dc != NONE || ic != NONE) && r < 70) begin
                if (r < 4)                   rsp = owned_tag();
                else if (r < 14 && ctg != 0) rsp = ctg;
                else                         rsp = free_tag();
            end
            step(0, dc, $urandom & 32'hFFFF_FFF8, {$urandom, $urandom},
                 ic, $urandom & 32'hFFFF_FFF8, rsp, ctg, {$urandom, $urandom});
        end
        idle(0, 0);
        idle(0, 0);
        @(negedge clock);
        #5;
        chk("status_queue_drained", 64'(stq.size()), 64'd0);
        chk("accept_queue_drained", 64'(accq.size()), 64'd0);
        chk("completion_queue_drained", 64'(cmpq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
